// File: rtl/layer_canvas_controller.sv
// Multi-layer canvas controller: tool write routing, layer clear engine
// and a two-stage priority compositor for video pixel requests.
module layer_canvas_controller #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int LAYERS      = 4,
  parameter int COLOR_WIDTH = 3,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT),
  localparam int ADDR_W = $clog2(WIDTH * HEIGHT),
  localparam int LW     = $clog2(LAYERS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          layer_next,
  input  logic [LAYERS-1:0]             layer_visible,
  input  logic                          clear_req,
  input  logic                          tool_valid,
  input  logic [XW-1:0]                 tool_x,
  input  logic [YW-1:0]                 tool_y,
  input  logic [COLOR_WIDTH-1:0]        tool_color,
  input  logic                          pixel_valid,
  input  logic [XW-1:0]                 pixel_x,
  input  logic [YW-1:0]                 pixel_y,
  input  logic [LAYERS*COLOR_WIDTH-1:0] rd_data,
  output logic [LAYERS-1:0]             wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [COLOR_WIDTH-1:0]        wr_data,
  output logic [ADDR_W-1:0]             rd_addr,
  output logic [LW-1:0]                 active_layer,
  output logic                          busy,
  output logic                          out_valid,
  output logic [COLOR_WIDTH-1:0]        out_color
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(WIDTH * HEIGHT - 1);
  localparam logic [LW-1:0] TOP_LAYER =
    LW'(LAYERS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                   state;
  logic                     next_q;
  logic                     clear_q;
  logic [ADDR_W-1:0]        count;
  logic [LW-1:0]            clear_layer;
  logic                     next_edge;
  logic                     clear_edge;
  logic                     tool_ok;
  logic [ADDR_W-1:0]        tool_addr;
  logic [ADDR_W-1:0]        pix_addr;
  logic [LAYERS-1:0]        active_hot;
  logic                     pix_v;
  logic [COLOR_WIDTH-1:0]   pick;

  assign next_edge  = layer_next & ~next_q;
  assign clear_edge = clear_req & ~clear_q;
  assign active_hot = LAYERS'(1) << active_layer;

  assign tool_addr = ADDR_W'(tool_y) * ADDR_W'(WIDTH)
                   + ADDR_W'(tool_x);
  assign pix_addr  = ADDR_W'(pixel_y) * ADDR_W'(WIDTH)
                   + ADDR_W'(pixel_x);

  assign tool_ok = tool_valid
                 && (32'(tool_x) < WIDTH)
                 && (32'(tool_y) < HEIGHT)
                 && layer_visible[active_layer];

  // A clear edge pre-empts both the tool pixel and a layer change.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      next_q       <= 1'b0;
      clear_q      <= 1'b0;
      count        <= '0;
      clear_layer  <= '0;
      active_layer <= '0;
      busy         <= 1'b0;
      wr_en        <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      next_q  <= layer_next;
      clear_q <= clear_req;
      wr_en   <= '0;
      unique case (state)
        IDLE: begin
          if (clear_edge) begin
            state       <= CLEAR;
            count       <= '0;
            busy        <= 1'b1;
            clear_layer <= active_layer;
          end else begin
            if (next_edge) begin
              active_layer <= (active_layer == TOP_LAYER)
                            ? '0 : active_layer + 1'b1;
            end
            if (tool_ok) begin
              wr_en   <= active_hot;
              wr_addr <= tool_addr;
              wr_data <= tool_color;
            end
          end
        end
        CLEAR: begin
          wr_en   <= LAYERS'(1) << clear_layer;
          wr_addr <= count;
          wr_data <= '0;
          count   <= count + 1'b1;
          if (count == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Later (higher) layers override lower ones.
  always_comb begin
    pick = '0;
    for (int i = 0; i < LAYERS; i++) begin
      if (layer_visible[i]
          && rd_data[i*COLOR_WIDTH +: COLOR_WIDTH] != '0) begin
        pick = rd_data[i*COLOR_WIDTH +: COLOR_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      pix_v     <= 1'b0;
      out_valid <= 1'b0;
      out_color <= '0;
    end else begin
      rd_addr   <= pix_addr;
      pix_v     <= pixel_valid;
      out_valid <= pix_v;
      if (pix_v) begin
        out_color <= pick;
      end
    end
  end

endmodule

// File: tb/tb_layer_canvas_controller.sv
// Scoreboard bench for layer_canvas_controller: directed stimulus queues
// expected writes/pixels, a negedge monitor pops and compares them.
module tb_layer_canvas_controller;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int L  = 4;
  localparam int CW = 3;
  localparam int AW = 3;

  logic          clk;
  logic          reset_n;
  logic          layer_next;
  logic [L-1:0]  layer_visible;
  logic          clear_req;
  logic          tool_valid;
  logic [1:0]    tool_x;
  logic [0:0]    tool_y;
  logic [CW-1:0] tool_color;
  logic          pixel_valid;
  logic [1:0]    pixel_x;
  logic [0:0]    pixel_y;
  logic [L*CW-1:0] rd_data;
  logic [L-1:0]  wr_en;
  logic [AW-1:0] wr_addr;
  logic [CW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [1:0]    active_layer;
  logic          busy;
  logic          out_valid;
  logic [CW-1:0] out_color;

  logic          o_tool_valid;
  logic [1:0]    o_tool_x;
  logic [1:0]    o_tool_y;
  logic [CW-1:0] o_tool_color;
  logic [L-1:0]  o_vis;
  logic [L-1:0]  o_wr_en;
  logic [3:0]    o_wr_addr;
  logic [CW-1:0] o_wr_data;
  logic [3:0]    o_rd_addr;
  logic [1:0]    o_active;
  logic          o_busy;
  logic          o_out_valid;
  logic [CW-1:0] o_out_color;

  layer_canvas_controller #(
    .WIDTH(W), .HEIGHT(H), .LAYERS(L), .COLOR_WIDTH(CW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .layer_next(layer_next), .layer_visible(layer_visible),
    .clear_req(clear_req), .tool_valid(tool_valid),
    .tool_x(tool_x), .tool_y(tool_y), .tool_color(tool_color),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .active_layer(active_layer),
    .busy(busy), .out_valid(out_valid), .out_color(out_color)
  );

  layer_canvas_controller #(
    .WIDTH(3), .HEIGHT(3), .LAYERS(L), .COLOR_WIDTH(CW)
  ) odd (
    .clk(clk), .reset_n(reset_n),
    .layer_next(1'b0), .layer_visible(o_vis),
    .clear_req(1'b0), .tool_valid(o_tool_valid),
    .tool_x(o_tool_x), .tool_y(o_tool_y),
    .tool_color(o_tool_color),
    .pixel_valid(1'b0), .pixel_x(2'd0), .pixel_y(2'd0),
    .rd_data(12'd0),
    .wr_en(o_wr_en), .wr_addr(o_wr_addr), .wr_data(o_wr_data),
    .rd_addr(o_rd_addr), .active_layer(o_active),
    .busy(o_busy), .out_valid(o_out_valid),
    .out_color(o_out_color)
  );

  typedef struct {
    logic [L-1:0]  en;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    int            at;
  } wr_t;

  typedef struct {
    logic [CW-1:0] c;
    int            at;
  } px_t;

  wr_t  wq[$];
  px_t  pq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    layer_next = 1'b1;
    step();
    layer_next = 1'b0;
    step();
  endtask

  task automatic push_wr(logic [L-1:0] en, int a, int d, int at);
    wr_t e;
    e.en   = en;
    e.addr = AW'(a);
    e.data = CW'(d);
    e.at   = at;
    wq.push_back(e);
  endtask

  task automatic push_px(int c, int at);
    px_t e;
    e.c  = CW'(c);
    e.at = at;
    pq.push_back(e);
  endtask

  wr_t we;
  px_t pe;
  always @(negedge clk) begin
    if (mon_on && wr_en != '0) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got en=%b addr=%0d",
                 wr_en, wr_addr);
      end else begin
        we = wq.pop_front();
        check("wr_en", int'(wr_en), int'(we.en));
        check("wr_addr", int'(wr_addr), int'(we.addr));
        check("wr_data", int'(wr_data), int'(we.data));
        check("wr_cycle", cyc, we.at);
      end
    end
    if (mon_on && out_valid) begin
      if (pq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got color=%0d",
                 out_color);
      end else begin
        pe = pq.pop_front();
        check("out_color", int'(out_color), int'(pe.c));
        check("out_cycle", cyc, pe.at);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  int k;
  int n;
  int exp_layer;

  initial begin
    reset_n       = 1'b0;
    layer_next    = 1'b0;
    layer_visible = '0;
    clear_req     = 1'b0;
    tool_valid    = 1'b0;
    tool_x        = '0;
    tool_y        = '0;
    tool_color    = '0;
    pixel_valid   = 1'b0;
    pixel_x       = '0;
    pixel_y       = '0;
    rd_data       = '0;
    o_tool_valid  = 1'b0;
    o_tool_x      = '0;
    o_tool_y      = '0;
    o_tool_color  = '0;
    o_vis         = '0;
    step();
    step();
    check("rst_active", int'(active_layer), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_wr_addr", int'(wr_addr), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_color", int'(out_color), 0);
    reset_n = 1'b1;
    mon_on  = 1'b1;

    for (int i = 0; i < 5; i++) begin
      pulse_next();
      exp_layer = (i + 1) % 4;
      check("layer_pulse", int'(active_layer), exp_layer);
    end
    layer_next = 1'b1;
    repeat (4) step();
    layer_next = 1'b0;
    step();
    check("layer_hold", int'(active_layer), 2);

    layer_visible = 4'b0100;
    tool_valid = 1'b1;
    tool_x = 2'd3;
    tool_y = 1'b1;
    tool_color = 3'd5;
    push_wr(4'b0100, 7, 5, cyc + 1);
    step();
    tool_valid = 1'b0;
    step();
    layer_visible = 4'b1011;
    tool_valid = 1'b1;
    step();
    check("tool_hidden", int'(wr_en), 0);
    layer_visible = 4'b0000;
    step();
    check("tool_none_vis", int'(wr_en), 0);
    tool_valid = 1'b0;
    step();

    repeat (3) pulse_next();
    check("layer_before_clear", int'(active_layer), 1);
    clear_req = 1'b1;
    k = cyc;
    for (int i = 0; i < 8; i++) push_wr(4'b0010, i, 0, k + 2 + i);
    step();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      n++;
      case (i)
        0: clear_req = 1'b0;
        1: begin
          tool_valid = 1'b1;
          layer_next = 1'b1;
          layer_visible = 4'b1111;
        end
        2: begin
          tool_valid = 1'b0;
          layer_next = 1'b0;
          clear_req = 1'b1;
        end
        3: clear_req = 1'b0;
        default: ;
      endcase
      step();
    end
    check("clear_busy_cycles", n, 8);
    check("clear_layer_kept", int'(active_layer), 1);
    step();
    step();
    check("clear_writes_left", wq.size(), 0);

    clear_req = 1'b1;
    k = cyc;
    for (int i = 0; i < 4; i++) push_wr(4'b0010, i, 0, k + 2 + i);
    step();
    clear_req = 1'b0;
    repeat (4) step();
    check("midclr_addr", int'(wr_addr), 3);
    check("midclr_busy", int'(busy), 1);
    reset_n = 1'b0;
    step();
    check("midrst_busy", int'(busy), 0);
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_layer", int'(active_layer), 0);
    reset_n = 1'b1;
    step();
    check("midrst_idle", int'(busy), 0);
    check("midrst_left", wq.size(), 0);

    rd_data = {3'd6, 3'd0, 3'd2, 3'd1};
    layer_visible = 4'b1111;
    pixel_x = 2'd1;
    pixel_y = 1'b1;
    pixel_valid = 1'b1;
    push_px(6, cyc + 2);
    step();
    pixel_valid = 1'b0;
    check("rd_addr", int'(rd_addr), 5);
    step();
    step();
    layer_visible = 4'b0100;
    pixel_valid = 1'b1;
    push_px(0, cyc + 2);
    step();
    pixel_valid = 1'b0;
    step();
    step();
    layer_visible = 4'b0111;
    pixel_valid = 1'b1;
    push_px(2, cyc + 2);
    step();
    pixel_valid = 1'b0;
    step();
    step();
    step();
    check("hold_valid", int'(out_valid), 0);
    check("hold_color", int'(out_color), 2);
    rd_data = {3'd0, 3'd0, 3'd0, 3'd3};
    layer_visible = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      pixel_x = 2'(i);
      pixel_valid = 1'b1;
      push_px(3, cyc + 2);
      step();
    end
    pixel_valid = 1'b0;
    repeat (3) step();
    check("burst_left", pq.size(), 0);

    repeat (3) pulse_next();
    check("layer_before_sim", int'(active_layer), 3);
    tool_valid = 1'b1;
    tool_x = 2'd1;
    tool_y = 1'b0;
    tool_color = 3'd2;
    layer_next = 1'b1;
    clear_req = 1'b1;
    k = cyc;
    for (int i = 0; i < 8; i++) push_wr(4'b1000, i, 0, k + 2 + i);
    step();
    tool_valid = 1'b0;
    layer_next = 1'b0;
    clear_req = 1'b0;
    repeat (10) step();
    check("sim_layer", int'(active_layer), 3);
    check("sim_busy", int'(busy), 0);
    check("sim_left", wq.size(), 0);

    o_vis = 4'b0001;
    o_tool_valid = 1'b1;
    o_tool_x = 2'd3;
    o_tool_y = 2'd0;
    o_tool_color = 3'd4;
    step();
    check("odd_x_range", int'(o_wr_en), 0);
    o_tool_x = 2'd0;
    o_tool_y = 2'd3;
    step();
    check("odd_y_range", int'(o_wr_en), 0);
    o_tool_x = 2'd2;
    o_tool_y = 2'd2;
    o_tool_color = 3'd7;
    step();
    o_tool_valid = 1'b0;
    check("odd_wr_en", int'(o_wr_en), 1);
    check("odd_wr_addr", int'(o_wr_addr), 8);
    check("odd_wr_data", int'(o_wr_data), 7);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/layer_canvas_controller.md
Name: layer_canvas_controller

Overview:
- Parametrised successor to the fixed two-canvas paint datapath.
- Manages LAYERS external single-port-write / sync-read canvas RAMs: routes freehand-tool writes to the active layer and cycles the active layer on a key pulse.
- Runs a sequential clear engine that wipes the active layer to COLOR_NONE.
- Produces a pipelined, priority-composited canvas colour for the video driver's pixel requests. Sits between the tool / PS/2 logic and the final camera/cursor compositor.

Parameters:
WIDTH, 640, canvas width in pixels
HEIGHT, 480, canvas height in pixels
LAYERS, 4, number of canvas layers (2..8)
COLOR_WIDTH, 3, bits per palette colour; value 0 is COLOR_NONE (transparent)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  synchronous active-low reset
layer_next  in  1  level from filtered key; rising edge advances active layer
layer_visible  in  LAYERS  per-layer visibility, bit i = layer i
clear_req  in  1  level; rising edge requests clear of active layer
tool_valid  in  1  tool pixel valid this cycle
tool_x  in  $clog2(WIDTH)  tool pixel x
tool_y  in  $clog2(HEIGHT)  tool pixel y
tool_color  in  COLOR_WIDTH  tool pixel colour
pixel_valid  in  1  video request valid
pixel_x  in  $clog2(WIDTH)  requested x
pixel_y  in  $clog2(HEIGHT)  requested y
rd_data  in  LAYERS*COLOR_WIDTH  RAM read data, layer i at [i*CW +: CW], valid 1 cycle after rd_addr
wr_en  out  LAYERS  one-hot write strobe
wr_addr  out  ADDR_W=$clog2(WIDTH*HEIGHT)  shared write address
wr_data  out  COLOR_WIDTH  shared write data
rd_addr  out  ADDR_W  shared read address to all layers
active_layer  out  $clog2(LAYERS)  current layer, for seg7 display
busy  out  1  clear in progress
out_valid  out  1  composite colour valid
out_color  out  COLOR_WIDTH  composited canvas colour

Behaviour:
- Reset values (reset_n=0 at a clk edge): active_layer=0, busy=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0, out_valid=0, out_color=COLOR_NONE, edge-detect registers=0, clear counter=0.
- Reset asserted mid-clear aborts the sweep immediately; already-written addresses stay cleared.
- Address arithmetic: addr = y*WIDTH + x, computed at ADDR_W.
- Tool coordinates with x>=WIDTH or y>=HEIGHT are dropped (no write).
- Edge detect: layer_next and clear_req are each registered, and act on the 0->1 transition only. Holding high produces one event.
- Layer select: on a layer_next edge with busy=0, active_layer <= (active_layer==LAYERS-1) ? 0 : active_layer+1. An edge while busy=1 is discarded, not queued.
- FSM states IDLE, CLEAR.
  - IDLE -> CLEAR on a clear_req edge. Counter <= 0, busy <= 1 next cycle. The cleared layer is the active_layer at the edge.
  - In CLEAR, each cycle: wr_en one-hot on the clear layer, wr_addr=counter, wr_data=COLOR_NONE, counter++.
  - After writing address WIDTH*HEIGHT-1 -> IDLE. busy falls the cycle after the last write.
  - A full clear takes exactly WIDTH*HEIGHT write cycles.
  - clear_req edge while in CLEAR: ignored.
  - Clear proceeds regardless of layer_visible.
- Tool writes (IDLE only): tool_valid=1, in range, and layer_visible[active_layer]=1 produce a registered write the next cycle:
  - wr_en = one-hot(active_layer)
  - wr_addr = tool address
  - wr_data = tool_color

  Otherwise wr_en=0. Latency is 1 cycle.
- Same-cycle priority:
  - clear_req edge with tool_valid: the clear wins and the tool pixel is dropped.
  - clear_req edge with layer_next edge: the clear targets the pre-change layer and layer_next is dropped.
  - Tool writes during CLEAR are dropped.
- Read/composite pipeline, 2 cycles, runs independently of FSM state:
  - Stage 1 registers rd_addr and the valid bit.
  - Stage 2 takes rd_data and selects the highest-index layer i with layer_visible[i]=1 and colour != COLOR_NONE. If none, the result is COLOR_NONE.
  - Stage 2 registers out_color and out_valid.
  - out_valid tracks pixel_valid delayed 2 cycles; out_color is held when out_valid=0.
  - Visibility is sampled in stage 2.

Test Plan (WIDTH=4, HEIGHT=2, LAYERS=4, COLOR_WIDTH=3):
1. Reset: hold reset_n=0 2 cycles -> active_layer=0, busy=0, wr_en=0, out_valid=0, out_color=0. Pulse layer_next 5 times -> active_layer 1,2,3,0,1. Hold layer_next high 4 cycles -> single increment.
2. Tool write: active_layer=2, layer_visible=4'b0100, tool (3,1,col 5) -> next cycle wr_en=4'b0100, wr_addr=7, wr_data=5. Repeat with layer_visible=0 -> wr_en=0. Tool (4,0) -> no write.
3. Clear: active_layer=1, clear_req edge -> busy=1 for 8 cycles, wr_en=4'b0010, wr_addr 0..7, wr_data=0, then busy=0. During the sweep, tool_valid and a layer_next edge -> no tool write, active_layer stays 1. A second clear_req edge during the sweep -> no restart.
4. Reset mid-clear: assert reset_n=0 at sweep address 3 -> next cycle busy=0, wr_en=0, state IDLE.
5. Composite: rd_data layers {0:1, 1:2, 2:0, 3:6}, all visible -> out_color=6 two cycles after pixel_valid. Layer 3 invisible -> 2. Only layer 2 visible -> 0. out_valid follows pixel_valid with 2-cycle delay across a 3-cycle burst.
6. Simultaneous events: clear_req edge + layer_next edge + tool_valid in one cycle at active_layer=3 -> clears layer 3 (wr_en=4'b1000), active_layer stays 3, no tool write.
